// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared states, request type encodings, AXI IDs and burst shaping
package cache_axi_pkg;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;
  typedef struct packed {
    logic [3:0] len;
    logic [2:0] size;
  } burst_t;
  function automatic burst_t burst_of(input logic [2:0] t);
    burst_t b;
    b.len = t == TYPE_LINE ? 4'd3 : 4'd0;
    b.size = t == TYPE_LINE ? 3'b010 : {1'b0, t[1:0]};
    return b;
  endfunction
endpackage

// File: rtl/axi_write_engine.sv
// axi_write_engine: single-entry write buffer sequencing AW, W and B for data-cache writes
module axi_write_engine
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [3:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready,
  output logic         wbuf_valid,
  output logic [31:0]  wbuf_addr
);
  w_state_t state, state_n;
  logic [127:0] buf_data;
  logic [3:0] buf_strb;
  burst_t buf_b;
  logic buf_line;
  logic [1:0] cnt;
  assign wr_rdy = state == W_IDLE;
  assign awvalid = state == W_AW;
  assign wvalid = state == W_DATA;
  assign bready = state == W_RESP;
  assign wlast = wvalid && {2'b00, cnt} == buf_b.len;
  assign awid = ID_DATA;
  assign wid = ID_DATA;
  assign awaddr = wbuf_addr;
  assign awlen = buf_b.len;
  assign awsize = buf_b.size;
  assign awburst = 2'b01;
  assign awlock = 2'b00;
  assign awcache = 4'd0;
  assign awprot = 3'd0;
  assign wdata = buf_data[{cnt, 5'd0} +: 32];
  assign wstrb = buf_line ? 4'hF : buf_strb;
  // state, buffer capture on acceptance, beat counter and buffer release on B
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W_IDLE;
      cnt <= 2'd0;
      wbuf_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (wr_rdy && wr_req) begin
        wbuf_valid <= 1'b1;
        wbuf_addr <= wr_addr;
        buf_data <= wr_data;
        buf_strb <= wr_wstrb;
        buf_b <= burst_of(wr_type);
        buf_line <= wr_type == TYPE_LINE;
      end
      if (wvalid && wready) cnt <= wlast ? 2'd0 : cnt + 2'd1;
      if (bvalid && bready) wbuf_valid <= 1'b0;
    end
  end
  // write sequencing: accept, address, data beats, response
  always_comb begin
    state_n = state;
    case (state)
      W_IDLE: if (wr_req) state_n = W_AW;
      W_AW: if (awready) state_n = W_DATA;
      W_DATA: if (wready && wlast) state_n = W_RESP;
      W_RESP: if (bvalid) state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end
endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI3 master between instruction and data caches
module cache_axi_arbiter
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req_inst,
  input  logic [2:0]   rd_type_inst,
  input  logic [31:0]  rd_addr_inst,
  output logic         rd_rdy_inst,
  output logic         ret_valid_inst,
  output logic         ret_last_inst,
  output logic [31:0]  ret_data_inst,
  input  logic         rd_req_data,
  input  logic [2:0]   rd_type_data,
  input  logic [31:0]  rd_addr_data,
  output logic         rd_rdy_data,
  output logic         ret_valid_data,
  output logic         ret_last_data,
  output logic [31:0]  ret_data_data,
  input  logic         wr_req_data,
  input  logic [2:0]   wr_type_data,
  input  logic [31:0]  wr_addr_data,
  input  logic [3:0]   wr_wstrb_data,
  input  logic [127:0] wr_data_data,
  output logic         wr_rdy_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [3:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [3:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  r_state_t r_state, r_state_n;
  logic last_grant, owner, pick_data, el_inst, el_data, accept;
  logic wbuf_valid;
  logic [31:0] wbuf_addr, ar_addr;
  burst_t ar_b;
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp};
  assign el_inst = rd_req_inst && !(wbuf_valid && rd_addr_inst[31:4] == wbuf_addr[31:4]);
  assign el_data = rd_req_data && !(wbuf_valid && rd_addr_data[31:4] == wbuf_addr[31:4]);
  assign pick_data = el_data && (!el_inst || !last_grant);
  assign rd_rdy_data = r_state == R_IDLE && pick_data;
  assign rd_rdy_inst = r_state == R_IDLE && el_inst && !pick_data;
  assign accept = rd_rdy_inst || rd_rdy_data;
  assign arvalid = r_state == R_AR;
  assign rready = r_state == R_DATA;
  assign arid = owner ? ID_DATA : ID_INST;
  assign araddr = ar_addr;
  assign arlen = ar_b.len;
  assign arsize = ar_b.size;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  assign ret_valid_inst = rready && rvalid && !owner;
  assign ret_valid_data = rready && rvalid && owner;
  assign ret_last_inst = ret_valid_inst && rlast;
  assign ret_last_data = ret_valid_data && rlast;
  assign ret_data_inst = ret_valid_inst ? rdata : 32'd0;
  assign ret_data_data = ret_valid_data ? rdata : 32'd0;
  // read state, latched request fields and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      last_grant <= 1'b0;
      owner <= 1'b0;
    end else begin
      r_state <= r_state_n;
      if (accept) begin
        owner <= pick_data;
        ar_addr <= pick_data ? rd_addr_data : rd_addr_inst;
        ar_b <= burst_of(pick_data ? rd_type_data : rd_type_inst);
      end
      if (rready && rvalid && rlast) last_grant <= owner;
    end
  end
  // one read burst at a time: grant, address, data
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE: if (accept) r_state_n = R_AR;
      R_AR: if (arready) r_state_n = R_DATA;
      R_DATA: if (rvalid && rlast) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end
  axi_write_engine u_wr (
    .clk(clk), .reset(reset),
    .wr_req(wr_req_data), .wr_type(wr_type_data), .wr_addr(wr_addr_data),
    .wr_wstrb(wr_wstrb_data), .wr_data(wr_data_data), .wr_rdy(wr_rdy_data),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .wbuf_valid(wbuf_valid), .wbuf_addr(wbuf_addr)
  );
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed and random checks of arbitration, routing, write sequencing and hazards
module tb_cache_axi_arbiter;
  import cache_axi_pkg::*;
  logic clk = 0, reset = 1;
  logic rd_req_inst = 0, rd_req_data = 0, wr_req_data = 0;
  logic [2:0] rd_type_inst = 0, rd_type_data = 0, wr_type_data = 0;
  logic [31:0] rd_addr_inst = 0, rd_addr_data = 0, wr_addr_data = 0;
  logic [3:0] wr_wstrb_data = 0;
  logic [127:0] wr_data_data = 0;
  logic rd_rdy_inst, rd_rdy_data, wr_rdy_data;
  logic ret_valid_inst, ret_last_inst, ret_valid_data, ret_last_data;
  logic [31:0] ret_data_inst, ret_data_data;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;
  logic arvalid, rready, awvalid, wlast, wvalid, bready;
  logic arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] rdata = 0;
  int checks = 0, errors = 0;
  bit last_w = 0, wb_pend = 0;
  logic [31:0] wb_a = 0;
  logic [2:0] types [4];

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req_inst(rd_req_inst), .rd_type_inst(rd_type_inst), .rd_addr_inst(rd_addr_inst), .rd_rdy_inst(rd_rdy_inst),
    .ret_valid_inst(ret_valid_inst), .ret_last_inst(ret_last_inst), .ret_data_inst(ret_data_inst),
    .rd_req_data(rd_req_data), .rd_type_data(rd_type_data), .rd_addr_data(rd_addr_data), .rd_rdy_data(rd_rdy_data),
    .ret_valid_data(ret_valid_data), .ret_last_data(ret_last_data), .ret_data_data(ret_data_data),
    .wr_req_data(wr_req_data), .wr_type_data(wr_type_data), .wr_addr_data(wr_addr_data),
    .wr_wstrb_data(wr_wstrb_data), .wr_data_data(wr_data_data), .wr_rdy_data(wr_rdy_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(4'd0), .rdata(rdata), .rresp(2'd0), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(4'd1), .bresp(2'd0), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic [31:0] a, input int b);
    return a ^ (32'h9E37_79B9 * (b + 1));
  endfunction

  function automatic bit hz(input logic [31:0] x);
    return wb_pend && x[31:4] == wb_a[31:4];
  endfunction

  task automatic rd(input bit ri, input bit di, input logic [31:0] ai, input logic [31:0] ad, input logic [2:0] t);
    bit ei, ed, w;
    logic [31:0] a;
    logic [3:0] len;
    logic [2:0] sz;
    int n;
    ei = ri && !hz(ai);
    ed = di && !hz(ad);
    w = ed && (!ei || !last_w);
    a = w ? ad : ai;
    len = t == TYPE_LINE ? 4'd3 : 4'd0;
    sz = t == TYPE_LINE ? 3'd2 : {1'b0, t[1:0]};
    @(negedge clk);
    rd_req_inst = ri; rd_req_data = di; rd_addr_inst = ai; rd_addr_data = ad; rd_type_inst = t; rd_type_data = t;
    #1;
    chk("rd_rdy_inst", rd_rdy_inst, ei && !w);
    chk("rd_rdy_data", rd_rdy_data, w);
    if (!ei && !ed) begin
      @(negedge clk);
      rd_req_inst = 0; rd_req_data = 0;
      return;
    end
    n = $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      rd_req_inst = 0; rd_req_data = 0; arready = i == n;
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      chk("arlen", arlen, len);
      chk("arsize", arsize, sz);
      chk("arid", arid, w ? 32'd1 : 32'd0);
      chk("rd_rdy_busy", {rd_rdy_inst, rd_rdy_data}, 0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        arready = 0; rvalid = 0;
        #1;
        chk("gap_ret_valid", {ret_valid_inst, ret_valid_data}, 0);
        chk("rready", rready, 1);
      end
      @(negedge clk);
      arready = 0; rvalid = 1; rlast = b == int'(len); rdata = beat(a, b);
      #1;
      chk("arvalid_drop", arvalid, 0);
      chk("ret_valid_own", w ? ret_valid_data : ret_valid_inst, 1);
      chk("ret_valid_other", w ? ret_valid_inst : ret_valid_data, 0);
      chk("ret_data", w ? ret_data_data : ret_data_inst, beat(a, b));
      chk("ret_last", w ? ret_last_data : ret_last_inst, b == int'(len));
    end
    @(negedge clk);
    rvalid = 0; rlast = 0;
    #1;
    chk("rready_after", rready, 0);
    chk("ret_valid_after", {ret_valid_inst, ret_valid_data}, 0);
    last_w = w;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s, input logic [127:0] d);
    logic [3:0] len;
    logic [2:0] sz;
    int n;
    len = t == TYPE_LINE ? 4'd3 : 4'd0;
    sz = t == TYPE_LINE ? 3'd2 : {1'b0, t[1:0]};
    @(negedge clk);
    wr_req_data = 1; wr_type_data = t; wr_addr_data = a; wr_wstrb_data = s; wr_data_data = d;
    #1;
    chk("wr_rdy_idle", wr_rdy_data, 1);
    wb_pend = 1; wb_a = a;
    n = $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      wr_req_data = 0; awready = i == n;
      #1;
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, a);
      chk("awlen", awlen, len);
      chk("awsize", awsize, sz);
      chk("awid", awid, 1);
      chk("wr_rdy_busy", wr_rdy_data, 0);
      chk("wvalid_early", wvalid, 0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        awready = 0; wready = 0;
        #1;
        chk("wvalid_hold", wvalid, 1);
        chk("wdata_hold", wdata, d[b*32 +: 32]);
      end
      @(negedge clk);
      awready = 0; wready = 1;
      #1;
      chk("awvalid_drop", awvalid, 0);
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, d[b*32 +: 32]);
      chk("wstrb", wstrb, t == TYPE_LINE ? 4'hF : s);
      chk("wlast", wlast, b == int'(len));
      chk("wid", wid, 1);
    end
    @(negedge clk);
    wready = 0;
    #1;
    chk("wvalid_done", wvalid, 0);
    chk("bready", bready, 1);
  endtask

  task automatic wr_resp(input int dly);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      #1;
      chk("bready_wait", bready, 1);
      chk("wr_rdy_wait", wr_rdy_data, 0);
    end
    @(negedge clk);
    bvalid = 1;
    #1;
    chk("wr_rdy_b", wr_rdy_data, 0);
    @(negedge clk);
    bvalid = 0; wb_pend = 0;
    #1;
    chk("wr_rdy_after_b", wr_rdy_data, 1);
    chk("bready_after_b", bready, 0);
  endtask

  initial begin
    types = '{TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_rdy", {rd_rdy_inst, rd_rdy_data}, 0);
    chk("rst_wr_rdy", wr_rdy_data, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, wlast}, 0);
    chk("rst_readies", {rready, bready}, 0);
    chk("rst_ret", {ret_valid_inst, ret_valid_data, ret_last_inst, ret_last_data}, 0);
    chk("rst_ret_data", ret_data_inst | ret_data_data, 0);
    chk("const_burst", {arburst, awburst}, 4'b0101);
    chk("const_misc", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
    @(negedge clk);
    reset = 0;
    // tie from reset goes to data, the next tie to inst
    rd(1, 1, 32'h0000_1000, 32'h0000_2000, TYPE_LINE);
    rd(1, 1, 32'h0000_3000, 32'h0000_4000, TYPE_LINE);
    rd(1, 0, 32'h1FC0_0000, 32'h0, TYPE_LINE);
    wr_issue(32'h0000_1230, TYPE_LINE, 4'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    wr_resp(5);
    // hazard: data read of the pending line stalls, inst read elsewhere proceeds
    wr_issue(32'h0000_0100, TYPE_LINE, 4'hF, 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678);
    rd(1, 1, 32'h0000_0200, 32'h0000_010C, TYPE_LINE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_req_data = 1; rd_addr_data = 32'h0000_010C; rd_type_data = TYPE_WORD;
      #1;
      chk("haz_stall", rd_rdy_data, 0);
    end
    wr_resp(2);
    chk("haz_release", rd_rdy_data, 1);
    rd_req_data = 0;
    rd(0, 1, 32'h0, 32'h0000_010C, TYPE_WORD);
    wr_issue(32'h0000_2003, TYPE_BYTE, 4'b0100, {96'h0, 32'h00AB_0000});
    wr_resp(1);
    // reset in the second beat of a burst
    @(negedge clk);
    rd_req_inst = 1; rd_addr_inst = 32'h1FC0_0040; rd_type_inst = TYPE_LINE;
    #1;
    chk("rst_mid_accept", rd_rdy_inst, 1);
    @(negedge clk);
    rd_req_inst = 0; arready = 1;
    #1;
    chk("rst_mid_ar", arvalid, 1);
    @(negedge clk);
    arready = 0; rvalid = 1; rdata = 32'h1111_0000;
    #1;
    chk("rst_mid_beat0", ret_valid_inst, 1);
    @(negedge clk);
    reset = 1; rdata = 32'h2222_0000;
    #1;
    chk("rst_mid_beat1", ret_data_inst, 32'h2222_0000);
    @(negedge clk);
    reset = 0; rvalid = 0;
    last_w = 0; wb_pend = 0;
    #1;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_ret", {ret_valid_inst, ret_valid_data}, 0);
    rd(1, 0, 32'h1FC0_0080, 32'h0, TYPE_LINE);
    // random traffic, optionally with a write pending across the read
    for (int k = 0; k < 30; k++) begin
      bit ri, di, wp;
      logic [31:0] ai, ad;
      wp = 1'($urandom_range(0, 1));
      if (wp) wr_issue($urandom, types[$urandom_range(0, 3)], 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      ri = 1'($urandom_range(0, 1));
      di = ri ? 1'($urandom_range(0, 1)) : 1'b1;
      ai = $urandom_range(0, 1) ? {wb_a[31:4], 4'($urandom)} : $urandom;
      ad = $urandom_range(0, 1) ? {wb_a[31:4], 4'($urandom)} : $urandom;
      rd(ri, di, ai, ad, types[$urandom_range(0, 3)]);
      if (wp) wr_resp($urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
